// File: rtl/uart_tx_scheduler_if.sv
// Requester/transmitter-side bundle of the UART TX scheduler.
// The slave modport is the scheduler; the master modport is the requester and transmitter side.
interface uart_tx_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    grant;
  logic [15:0]         tx_data;
  logic                tx_en;
  logic                busy;
  logic                done;

  modport master (
    output req, req_data,
    input  grant, tx_data, tx_en, busy, done
  );

  modport slave (
    input  req, req_data,
    output grant, tx_data, tx_en, busy, done
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing a 2-byte UART transmitter that has no busy/done feedback.
// Frame length is tracked by cycle count; tx_data is held for the whole frame and gap.
module uart_tx_scheduler #(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = 20,
  parameter int GAP_CYCLES   = 2
) (
  input logic                clk_9k6hz,
  input logic                rst,
  uart_tx_scheduler_if.slave bus
);
  localparam int CNT_W = $clog2(FRAME_CYCLES + GAP_CYCLES + 2);
  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(FRAME_CYCLES + GAP_CYCLES);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    S_HOLDOFF = 3'd0,
    S_IDLE    = 3'd1,
    S_FIRE    = 3'd2,
    S_FRAME   = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [PTR_W-1:0]   rr_ptr_r;

  logic               found_s;
  logic [PTR_W-1:0]   winner_s;
  logic [PTR_W-1:0]   next_ptr_s;
  logic [N_REQ-1:0]   onehot_s;
  logic [15:0]        sel_data_s;

  // Round-robin winner search starting at rr_ptr_r, wrapping modulo N_REQ.
  always_comb begin
    logic [PTR_W-1:0] idx_v;
    found_s  = 1'b0;
    winner_s = rr_ptr_r;
    idx_v    = rr_ptr_r;
    for (int k = 0; k < N_REQ; k++) begin
      idx_v = PTR_W'((int'(rr_ptr_r) + k) % N_REQ);
      if (!found_s && bus.req[idx_v]) begin
        found_s  = 1'b1;
        winner_s = idx_v;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Grant vector, word select and the pointer value following the winner.
  always_comb begin
    onehot_s   = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
    sel_data_s = bus.req_data[16*winner_s +: 16];
    if (winner_s == PTR_W'(N_REQ - 1)) begin
      next_ptr_s = {PTR_W{1'b0}};
    end else begin
      next_ptr_s = winner_s + {{(PTR_W-1){1'b0}}, 1'b1};
    end
  end

  // Scheduler FSM with all outputs registered; HOLDOFF covers a transmitter still mid-frame after reset.
  always_ff @(posedge clk_9k6hz) begin
    if (rst) begin
      state_r     <= S_HOLDOFF;
      cnt_r       <= {CNT_W{1'b0}};
      rr_ptr_r    <= {PTR_W{1'b0}};
      bus.grant   <= {N_REQ{1'b0}};
      bus.tx_data <= 16'h0000;
      bus.tx_en   <= 1'b0;
      bus.busy    <= 1'b1;
      bus.done    <= 1'b0;
    end else begin
      case (state_r)
        S_HOLDOFF: begin
          if (cnt_r == HOLD_LAST) begin
            cnt_r    <= {CNT_W{1'b0}};
            bus.busy <= 1'b0;
            state_r  <= S_IDLE;
          end else begin
            cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_IDLE: begin
          if (found_s) begin
            bus.tx_data <= sel_data_s;
            bus.grant   <= onehot_s;
            bus.tx_en   <= 1'b1;
            bus.busy    <= 1'b1;
            rr_ptr_r    <= next_ptr_s;
            state_r     <= S_FIRE;
          end
        end
        S_FIRE: begin
          bus.tx_en <= 1'b0;
          bus.grant <= {N_REQ{1'b0}};
          cnt_r     <= {CNT_W{1'b0}};
          state_r   <= S_FRAME;
        end
        S_FRAME: begin
          if (cnt_r == FRAME_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
            if (GAP_CYCLES == 0) begin
              bus.done <= 1'b1;
              state_r  <= S_DONE;
            end else begin
              state_r  <= S_GAP;
            end
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r    <= {CNT_W{1'b0}};
            bus.done <= 1'b1;
            state_r  <= S_DONE;
          end else begin
            cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state_r  <= S_IDLE;
        end
        default: begin
          state_r   <= S_HOLDOFF;
          cnt_r     <= {CNT_W{1'b0}};
          bus.grant <= {N_REQ{1'b0}};
          bus.tx_en <= 1'b0;
          bus.busy  <= 1'b1;
          bus.done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus pushes expected grant/done events with their
// clock edge; monitors pop and compare whenever a DUT presents a grant or done pulse.
module tb_uart_tx_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.N_REQ(4)) bus ();
  uart_tx_scheduler_if #(.N_REQ(4)) bus0 ();

  uart_tx_scheduler #(.N_REQ(4), .FRAME_CYCLES(20), .GAP_CYCLES(2)) dut (
    .clk_9k6hz(clk), .rst(rst), .bus(bus)
  );
  uart_tx_scheduler #(.N_REQ(4), .FRAME_CYCLES(20), .GAP_CYCLES(0)) dut0 (
    .clk_9k6hz(clk), .rst(rst), .bus(bus0)
  );

  typedef struct {
    bit          kind;   // 0 = grant, 1 = done
    logic [3:0]  g;
    logic [15:0] d;
    int          e;
  } ev_t;

  ev_t q[$];
  ev_t q0[$];
  int  total = 0;
  int  bad = 0;
  int  edge_n = 0;
  bit  rst_seen = 1'b0;
  bit  mon_on = 1'b0;
  int  r1, r2, r3;

  always @(posedge clk) begin
    edge_n   <= edge_n + 1;
    rst_seen <= rst;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  function automatic void exp_ev(input bit kind, input int e, input logic [3:0] g, input logic [15:0] d);
    ev_t ev;
    ev.kind = kind; ev.e = e; ev.g = g; ev.d = d;
    q.push_back(ev);
  endfunction

  function automatic void exp_ev0(input int e);
    ev_t ev;
    ev.kind = 1'b0; ev.e = e; ev.g = 4'b0001; ev.d = 16'hBEEF;
    q0.push_back(ev);
  endfunction

  task automatic go_to(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Main DUT monitor: scoreboard pop plus a bench-side model of tx_en and tx_data.
  initial begin
    ev_t         ev;
    logic        exp_en;
    logic [15:0] exp_data;
    exp_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        exp_en = 1'b0;
        if (rst_seen) exp_data = 16'h0000;
        if (bus.grant != 4'b0000 || bus.done) begin
          if (q.size() == 0) begin
            chk("unexpected_event", 64'({bus.grant, bus.done}), 64'd0);
          end else begin
            ev = q.pop_front();
            chk("event_edge", 64'(edge_n), 64'(ev.e));
            chk("event_kind", 64'(bus.done), 64'(ev.kind));
            if (ev.kind == 1'b0) begin
              chk("grant", 64'(bus.grant), 64'(ev.g));
              exp_en   = 1'b1;
              exp_data = ev.d;
            end
          end
        end
        chk("tx_en", 64'(bus.tx_en), 64'(exp_en));
        chk("tx_data", 64'(bus.tx_data), 64'(exp_data));
      end
    end
  end

  // GAP_CYCLES=0 DUT monitor.
  initial begin
    ev_t         ev;
    logic        exp_en;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        exp_en = 1'b0;
        if (bus0.grant != 4'b0000) begin
          if (q0.size() == 0) begin
            chk("gap0_unexpected_grant", 64'(bus0.grant), 64'd0);
          end else begin
            ev = q0.pop_front();
            chk("gap0_edge", 64'(edge_n), 64'(ev.e));
            chk("gap0_grant", 64'(bus0.grant), 64'(ev.g));
            chk("gap0_tx_data", 64'(bus0.tx_data), 64'(ev.d));
            exp_en = 1'b1;
          end
        end
        chk("gap0_tx_en", 64'(bus0.tx_en), 64'(exp_en));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a request already pending; it must wait out HOLDOFF.
    rst = 1'b1;
    bus.req = 4'b0001;
    bus.req_data = {16'h0000, 16'h0000, 16'h0000, 16'hA55A};
    bus0.req = 4'b0001;
    bus0.req_data = {48'h0, 16'hBEEF};
    @(posedge clk);
    #2;
    rst = 1'b0;
    r1 = edge_n;
    chk("reset_vals_1", 64'({bus.grant, bus.tx_data, bus.tx_en, bus.done, bus.busy}), 64'({4'b0000, 16'h0000, 1'b0, 1'b0, 1'b1}));
    mon_on = 1'b1;
    exp_ev(1'b0, r1 + 24, 4'b0001, 16'hA55A);
    exp_ev(1'b1, r1 + 47, 4'b0000, 16'h0000);
    exp_ev0(r1 + 22);
    exp_ev0(r1 + 45);
    exp_ev0(r1 + 68);

    go_to(r1 + 22);
    chk("busy_holdoff_end", 64'(bus.busy), 64'd1);
    go_to(r1 + 23);
    chk("busy_idle", 64'(bus.busy), 64'd0);
    go_to(r1 + 24);
    bus.req = 4'b0000;
    go_to(r1 + 68);
    bus0.req = 4'b0000;

    // All requesters pending; rst on the same edge must win, then order 0,1,2,3,0.
    go_to(r1 + 70);
    bus.req = 4'b1111;
    bus.req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    rst = 1'b1;
    go_to(r1 + 71);
    rst = 1'b0;
    r2 = edge_n;
    exp_ev(1'b0, r2 + 24,  4'b0001, 16'h1111);
    exp_ev(1'b1, r2 + 47,  4'b0000, 16'h0000);
    exp_ev(1'b0, r2 + 49,  4'b0010, 16'h2222);
    exp_ev(1'b1, r2 + 72,  4'b0000, 16'h0000);
    exp_ev(1'b0, r2 + 74,  4'b0100, 16'h3333);
    exp_ev(1'b1, r2 + 97,  4'b0000, 16'h0000);
    exp_ev(1'b0, r2 + 99,  4'b1000, 16'h4444);
    exp_ev(1'b1, r2 + 122, 4'b0000, 16'h0000);
    exp_ev(1'b0, r2 + 124, 4'b0001, 16'h1111);
    exp_ev(1'b1, r2 + 147, 4'b0000, 16'h0000);
    go_to(r2 + 124);
    bus.req = 4'b0000;

    // Grant requester 2 so rr_ptr becomes 3, then req=0101 must go 0 first, then 2.
    go_to(r2 + 150);
    bus.req = 4'b0100;
    exp_ev(1'b0, r2 + 151, 4'b0100, 16'h3333);
    exp_ev(1'b1, r2 + 174, 4'b0000, 16'h0000);
    go_to(r2 + 151);
    bus.req = 4'b0000;
    bus.req_data[15:0]  = 16'hAAAA;
    bus.req_data[47:32] = 16'hCCCC;
    go_to(r2 + 170);
    bus.req = 4'b0101;
    exp_ev(1'b0, r2 + 176, 4'b0001, 16'hAAAA);
    exp_ev(1'b1, r2 + 199, 4'b0000, 16'h0000);
    exp_ev(1'b0, r2 + 201, 4'b0100, 16'hCCCC);
    exp_ev(1'b1, r2 + 224, 4'b0000, 16'h0000);
    go_to(r2 + 176);
    bus.req = 4'b0100;
    // Requester 0 word churns every cycle while its frame is on the line.
    for (int i = 177; i <= 199; i++) begin
      go_to(r2 + i);
      bus.req_data[15:0] = 16'h0100 + 16'(i);
    end
    go_to(r2 + 201);
    bus.req = 4'b0000;

    // Reset in FRAME cycle 7 with requester 1 still pending.
    go_to(r2 + 226);
    bus.req = 4'b0010;
    bus.req_data[31:16] = 16'h5555;
    exp_ev(1'b0, r2 + 227, 4'b0010, 16'h5555);
    go_to(r2 + 227);
    bus.req_data[31:16] = 16'h6666;
    go_to(r2 + 235);
    rst = 1'b1;
    go_to(r2 + 236);
    rst = 1'b0;
    r3 = edge_n;
    chk("reset_vals_frame", 64'({bus.grant, bus.tx_data, bus.tx_en, bus.done, bus.busy}), 64'({4'b0000, 16'h0000, 1'b0, 1'b0, 1'b1}));
    exp_ev(1'b0, r3 + 24, 4'b0010, 16'h6666);
    exp_ev(1'b1, r3 + 47, 4'b0000, 16'h0000);
    go_to(r3 + 24);
    bus.req = 4'b0000;

    go_to(r3 + 60);
    chk("events_left", 64'(q.size()), 64'd0);
    chk("gap0_events_left", 64'(q0.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
